inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Parametrised instruction fetch unit: owns the program counter, a loadable synchronous instruction memory and a two-entry output buffer. It streams `{pc, instruction}` pairs to decode over a valid/ready handshake, with backpressure, branch/jump redirect with flush, and a runtime load port. Memory contents come from the load port, not from file initialisation.

## Interface
- `INSTR_W`, 32, instruction width in bits
- `DEPTH`, 64, memory depth in words; power of two, ≥ 4
- `ADDR_W`, `$clog2(DEPTH)`, word-address / PC width
- `RESET_PC`, 0, PC value after reset
- `CNT_W`, 32, width of the accepted-instruction counter
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  fetch enable; when low, no new reads are issued
- `redirect_valid`  in  1  load `redirect_pc` and flush the pipeline
- `redirect_pc`  in  ADDR_W  redirect target (word address)
- `ld_we`  in  1  memory write strobe
- `ld_addr`  in  ADDR_W  memory write address
- `ld_data`  in  INSTR_W  memory write data
- `out_valid`  out  1  `out_instr`/`out_pc` valid
- `out_ready`  in  1  decode accepts the current output
- `out_instr`  out  INSTR_W  fetched instruction
- `out_pc`  out  ADDR_W  address of `out_instr`
- `instr_count`  out  CNT_W  number of accepted transfers, saturating

## Operation
- Reset values: `fetch_pc`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, skid empty, no read in flight, `instr_count`=0. Memory contents are not reset.
- FSM in `ifu_pkg::ifu_state_t`:
  - IDLE: `en`=0. Go to RUN when `en`=1.
  - RUN: issue reads. Go to IDLE when `en`=0; in-flight data still drains.
  - FLUSH: one cycle after a redirect. No output is valid. Go to RUN or IDLE according to `en`.
- Issue rule, evaluated in RUN: issue a read at `fetch_pc` when the skid buffer is empty and not (a read is in flight and the output is stalled). On each issue, `fetch_pc` <= `fetch_pc`+1 modulo 2^ADDR_W, so DEPTH-1 wraps to 0.
- Buffering:
  - In-flight data goes to the output register when it is empty or being accepted; otherwise it goes to the skid register.
  - When the output register is accepted, the skid register moves into it.
  - No instruction is lost or duplicated.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_instr`/`out_pc` hold stable. A transfer occurs only when `out_valid` and `out_ready` are both 1.
- Redirect (highest priority):
  - A transfer in the same cycle still completes and is counted.
  - The in-flight read, skid and output register are then discarded: `out_valid`=0 next cycle.
  - `fetch_pc` <= `redirect_pc`. State goes to FLUSH.
  - Redirect while in IDLE updates the PC only.
- Load port:
  - A write commits at the edge.
  - Read-during-write to the same address returns the old data (read-first).
  - Writes do not invalidate buffered instructions.
- `instr_count` increments by 1 on each transfer and saturates at 2^CNT_W-1.

## Timing
- Memory read latency is 1 cycle. The first instruction appears 2 cycles after `en` rises: cycle N `en`=1; N+1 read at RESET_PC; N+2 `out_valid`=1.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- Redirect asserted in cycle N: `out_valid`=0 in N+1 (FLUSH) and N+2; target instruction valid in N+3.
- `out_ready` low can stall with at most 2 instructions buffered; no combinational path from `out_ready` to `out_valid`.
- Asynchronous reset clears all state immediately, including mid-stream. After deassertion, fetch restarts at RESET_PC as from IDLE.

## Structure
- `ifu_pkg`: `ifu_state_t` enum {IDLE, RUN, FLUSH}; `IFU_NOP` constant (all zeros, used as reset/flush value of `out_instr`).
- Sub-module `ifu_imem`: simple dual-port synchronous RAM (one write port, one read port, read-first), parametrised by `INSTR_W`/`DEPTH`.
- Top level contains the PC, FSM, in-flight flag, output and skid registers, and counter.

## Test plan
- Reset, load words 0..3 with 0x11,0x22,0x33,0x44, raise `en` with `out_ready`=1: `out_valid` at N+2; pairs (0,0x11),(1,0x22),(2,0x33),(3,0x44) on consecutive cycles; `instr_count`=4.
- Hold `out_ready`=0 for 3 cycles while pc 2 is presented: `out_pc`=2/0x33 stable; after release, pcs 3, 4 follow with no gap or duplicate.
- Stall holding pc 2 with pc 3 in skid, assert `redirect_valid` with `redirect_pc`=10: `out_valid`=0 for 2 cycles, then `out_pc`=10; pc 3 never transfers; count unchanged by the flushed instructions.
- `redirect_pc`=DEPTH-2 with `out_ready`=1: output pcs DEPTH-2, DEPTH-1, 0, 1.
- Drop `rst` mid-stream: `out_valid`=0 and `instr_count`=0 immediately; after release, first output at RESET_PC, and memory still holds the loaded program.
- Write 0xAA to address 5 in the same cycle a read of 5 issues: that fetch returns the old word; the next fetch of 5 returns 0xAA.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ifu_pkg                                                |
// | Purpose  : Shared types and constants for the instruction fetch   |
// |            unit (FSM state encoding, NOP/flush instruction).      |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ifu_pkg;

   // Fetch control state; explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } ifu_state_t;

   // All-zero instruction used for reset and flush of the output register.
   // Wide enough for any practical INSTR_W; users cast it to their width.
   localparam logic [127:0] IFU_NOP = '0;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_imem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ifu_imem                                               |
// | Purpose  : Simple dual-port synchronous instruction RAM, one      |
// |            write port and one read port, read-first behaviour.    |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ifu_imem #(
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 64,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic               re,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Write and read in the same process: the non-blocking update makes a
   // same-address read return the old word (read-first)
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : ifu_imem
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : inst_fetch_unit                                        |
// | Purpose  : Program counter, loadable instruction memory and a     |
// |            two-entry output buffer streaming {pc, instr} pairs    |
// |            over valid/ready, with redirect/flush.                 |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module inst_fetch_unit
   import ifu_pkg::*;
#(
   parameter int          INSTR_W  = 32,
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = $clog2(DEPTH),
   parameter int unsigned RESET_PC = 0,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               ld_we,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [INSTR_W-1:0] ld_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [CNT_W-1:0]   instr_count
);

   localparam logic [ADDR_W-1:0]  PC_RST  = ADDR_W'(RESET_PC);
   localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(IFU_NOP);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

   ifu_state_t         state, next_state;
   logic [ADDR_W-1:0]  fetch_pc;
   logic               inflight;
   logic [ADDR_W-1:0]  inflight_pc;
   logic [INSTR_W-1:0] mem_rdata;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc;
   logic               issue;
   logic               flush;
   logic               transfer;
   logic               stalled;

   assign transfer = out_valid & out_ready;
   assign stalled  = out_valid & ~out_ready;

   ifu_imem #(
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) u_imem (
      .clk   (clk),
      .we    (ld_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (issue),
      .raddr (fetch_pc),
      .rdata (mem_rdata)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state: redirect outside IDLE forces one FLUSH cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = en ? RUN : IDLE;
         RUN:     next_state = redirect_valid ? FLUSH : (en ? RUN : IDLE);
         FLUSH:   next_state = redirect_valid ? FLUSH : (en ? RUN : IDLE);
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs: a read is launched in the cycle before RUN so its data
   // lands one cycle into RUN; the buffer bound limits it to two entries
   always_comb begin
      flush = redirect_valid && (state != IDLE);
      issue = 1'b0;
      if ((next_state == RUN) && !redirect_valid) begin
         issue = !skid_valid && !(inflight && stalled);
      end
   end

   // Program counter: redirect wins over sequential advance (wraps naturally)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= PC_RST;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
      end else if (issue) begin
         fetch_pc <= fetch_pc + 1'b1;
      end
   end

   // In-flight tracking: remembers which PC the RAM output belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue && !flush;
         if (issue) begin
            inflight_pc <= fetch_pc;
         end
      end
   end

   // Output and skid registers: skid drains first so order is preserved
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_instr  <= NOP;
         out_pc     <= '0;
         skid_valid <= 1'b0;
         skid_instr <= NOP;
         skid_pc    <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         out_instr  <= NOP;
         out_pc     <= '0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            skid_valid <= 1'b0;
         end else if (inflight) begin
            out_valid <= 1'b1;
            out_instr <= mem_rdata;
            out_pc    <= inflight_pc;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (inflight) begin
         skid_valid <= 1'b1;
         skid_instr <= mem_rdata;
         skid_pc    <= inflight_pc;
      end
   end

   // Accepted-transfer counter, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_count <= '0;
      end else if (transfer && (instr_count != CNT_MAX)) begin
         instr_count <= instr_count + 1'b1;
      end
   end

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_inst_fetch_unit                                     |
// | Purpose  : Directed self-checking bench for inst_fetch_unit with  |
// |            a queue scoreboard of expected {pc, instr} transfers.  |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_inst_fetch_unit;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int IW    = 32;
   localparam int CW    = 32;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } item_t;

   logic          clk;
   logic          rst;
   logic          en;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [IW-1:0] ld_data;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic [CW-1:0] instr_count;

   int            checks = 0;
   int            errors = 0;
   item_t         sb[$];
   logic [IW-1:0] model [DEPTH];

   inst_fetch_unit #(
      .INSTR_W  (IW),
      .DEPTH    (DEPTH),
      .ADDR_W   (AW),
      .RESET_PC (0),
      .CNT_W    (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ld_we          (ld_we),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .instr_count    (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int p);
      item_t it;
      it.pc    = AW'(p);
      it.instr = model[p];
      sb.push_back(it);
   endtask

   task automatic wait_pc(input int p, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (out_valid && (out_pc == AW'(p))) found = 1'b1;
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL %s observed=timeout expected=pc %0d", tag, p);
      end
   endtask

   // Pulse redirect for one cycle; returns in the cycle after the redirect
   task automatic redirect_to(input int p);
      redirect_valid = 1'b1;
      redirect_pc    = AW'(p);
      step();
      redirect_valid = 1'b0;
   endtask

   // Scoreboard: every accepted transfer must match the oldest expectation
   always @(negedge clk) begin
      item_t it;
      if (rst && out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=pc %0d expected=no transfer", out_pc);
         end
         if (sb.size() != 0) begin
            it = sb.pop_front();
            chk("sb_pc", 64'(out_pc), 64'(it.pc));
            chk("sb_instr", 64'(out_instr), 64'(it.instr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = (i < 4) ? IW'(32'h11 * (i + 1)) : IW'(32'h1000 + i);
      end
      rst = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_count", 64'(instr_count), 64'd0);
      step(); step();
      rst = 1'b1;

      // Load the whole program through the load port
      for (int i = 0; i < DEPTH; i++) begin
         step();
         ld_we = 1'b1; ld_addr = AW'(i); ld_data = model[i];
      end
      step();
      ld_we = 1'b0;

      // Start-up latency and back-to-back stream
      for (int i = 0; i <= 4; i++) push(i);
      en = 1'b1; out_ready = 1'b1;
      step();
      chk("lat_n1_valid", 64'(out_valid), 64'd0);
      step();
      chk("lat_n2_valid", 64'(out_valid), 64'd1);
      chk("lat_n2_pc", 64'(out_pc), 64'd0);
      chk("lat_n2_instr", 64'(out_instr), 64'h11);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_pc", 64'(out_pc), 64'(i));
      end
      chk("count_after_4", 64'(instr_count), 64'd4);

      // Redirect to 0 while pc 4 transfers; then stall on pc 2
      redirect_to(0);
      chk("redir_same_cycle_count", 64'(instr_count), 64'd5);
      chk("redir_n1_valid", 64'(out_valid), 64'd0);
      step();
      chk("redir_n2_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i <= 4; i++) push(i);
      step();
      chk("redir_n3_pc", 64'(out_pc), 64'd0);
      step();
      step();
      out_ready = 1'b0;
      chk("stall_pc_first", 64'(out_pc), 64'd2);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_pc", 64'(out_pc), 64'd2);
         chk("stall_instr", 64'(out_instr), 64'h33);
      end
      step();
      out_ready = 1'b1;
      wait_pc(4, "wait_pc4");

      // Stall pc 2 with pc 3 in skid, then redirect to 10
      redirect_to(2);
      out_ready = 1'b0;
      chk("count_10", 64'(instr_count), 64'd10);
      wait_pc(2, "wait_pc2");
      step(); step();
      chk("skid_hold_pc", 64'(out_pc), 64'd2);
      redirect_to(10);
      out_ready = 1'b1;
      chk("flush_n1_valid", 64'(out_valid), 64'd0);
      chk("flush_count", 64'(instr_count), 64'd10);
      step();
      chk("flush_n2_valid", 64'(out_valid), 64'd0);
      push(10);
      step();
      chk("flush_n3_valid", 64'(out_valid), 64'd1);
      chk("flush_n3_pc", 64'(out_pc), 64'd10);

      // PC wrap from DEPTH-2
      redirect_to(DEPTH - 2);
      push(DEPTH - 2); push(DEPTH - 1); push(0); push(1);
      wait_pc(1, "wait_wrap");

      // Read-during-write on address 5 returns the old word
      redirect_to(5);
      ld_we = 1'b1; ld_addr = AW'(5); ld_data = 32'hAA;
      push(5);
      model[5] = 32'hAA;
      step();
      ld_we = 1'b0;
      wait_pc(5, "wait_rdw_old");
      redirect_to(5);
      push(5);
      wait_pc(5, "wait_rdw_new");
      step();
      chk("pre_reset_count", 64'(instr_count), 64'd17);
      chk("pre_reset_pc", 64'(out_pc), 64'd6);

      // Asynchronous reset mid-stream
      rst = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_count", 64'(instr_count), 64'd0);
      step(); step();
      push(0); push(1);
      rst = 1'b1;
      wait_pc(2, "wait_restart");
      chk("restart_count", 64'(instr_count), 64'd2);
      rst = 1'b0; en = 1'b0;
      #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_inst_fetch_unit
`default_nettype wire
